mem_stage: RTL and testbench

- MEM pipeline stage. Sits between EX and WB and feeds the WB stage's valid/allowin handshake and result fields.
- Waits for the data-side response (`data_ok`) of loads/stores issued in EX. Aligns and extends load data and forwards the exception flag unchanged.
- After a pipeline flush, discards responses still in flight for cancelled requests.

---
 rtl/mem_stage.sv | 149 ++++++++++++++
 tb/tb_mem_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for data-side responses, aligns/extends load data, drops stale
// responses after a flush. Define MS_RDATA_BUF_EN to hold rdata while WB back-pressures.
module mem_stage #(
    parameter int unsigned DISCARD_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        es_to_ms_valid,
    output logic        ms_allowin,
    input  logic [31:0] es_pc,
    input  logic [31:0] es_result,
    input  logic [4:0]  es_dest,
    input  logic        es_gr_we,
    input  logic [2:0]  es_ld_op,
    input  logic        es_mem_req,
    input  logic        es_ex,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc,
    output logic [31:0] ms_final_result,
    output logic [4:0]  ms_dest,
    output logic        ms_gr_we,
    output logic        ms_ex,
    input  logic        wb_flush,
    output logic [4:0]  ms_fwd_dest,
    output logic        ms_fwd_blocking
);

    localparam logic [DISCARD_W-1:0] CntMax = '1;

    logic                 ms_valid;
    logic                 waiting;
    logic [DISCARD_W-1:0] discard_cnt;
    logic [31:0]          ms_result;
    logic [2:0]           ms_ld_op;

    logic        resp_hit;
    logic        ms_ready_go;
    logic        capture;
    logic        disc_inc;
    logic        disc_dec;
    logic [31:0] load_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

`ifdef MS_RDATA_BUF_EN
    logic        buf_valid;
    logic [31:0] buf_data;
`endif

    always_comb begin
        resp_hit       = data_sram_data_ok && (discard_cnt == '0) && waiting;
        ms_ready_go    = !waiting || resp_hit;
        ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
        ms_to_ws_valid = ms_valid && ms_ready_go && !wb_flush;
        capture        = es_to_ms_valid && ms_allowin && !wb_flush;
        // A flushed request whose response is still out must have that response dropped later
        disc_inc       = wb_flush && waiting && !resp_hit;
        disc_dec       = data_sram_data_ok && (discard_cnt != '0);
    end

    always_comb begin
`ifdef MS_RDATA_BUF_EN
        load_data = buf_valid ? buf_data : data_sram_rdata;
`else
        load_data = data_sram_rdata;
`endif
        byte_sel = load_data[{ms_result[1:0], 3'b000} +: 8];
        half_sel = load_data[{ms_result[1], 4'b0000} +: 16];
        case (ms_ld_op)
            3'd1:    ms_final_result = load_data;
            3'd2:    ms_final_result = {{24{byte_sel[7]}}, byte_sel};
            3'd3:    ms_final_result = {24'd0, byte_sel};
            3'd4:    ms_final_result = {{16{half_sel[15]}}, half_sel};
            3'd5:    ms_final_result = {16'd0, half_sel};
            default: ms_final_result = ms_result;
        endcase
    end

    always_comb begin
        ms_fwd_dest     = (ms_valid && ms_gr_we) ? ms_dest : 5'd0;
        ms_fwd_blocking = ms_valid && (ms_ld_op != 3'd0) && waiting && !resp_hit;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid    <= 1'b0;
            waiting     <= 1'b0;
            discard_cnt <= '0;
            ms_pc       <= 32'd0;
            ms_result   <= 32'd0;
            ms_dest     <= 5'd0;
            ms_gr_we    <= 1'b0;
            ms_ld_op    <= 3'd0;
            ms_ex       <= 1'b0;
        end else begin
            if (wb_flush) begin
                ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end

            if (capture) begin
                ms_pc     <= es_pc;
                ms_result <= es_result;
                ms_dest   <= es_dest;
                ms_gr_we  <= es_gr_we;
                ms_ld_op  <= es_ld_op;
                ms_ex     <= es_ex;
                waiting   <= es_mem_req && !es_ex;
            end else if (wb_flush || resp_hit) begin
                waiting <= 1'b0;
            end

            unique case ({disc_inc, disc_dec})
                2'b10: if (discard_cnt != CntMax) discard_cnt <= discard_cnt + DISCARD_W'(1);
                2'b01: discard_cnt <= discard_cnt - DISCARD_W'(1);
                default: discard_cnt <= discard_cnt;
            endcase
        end
    end

`ifdef MS_RDATA_BUF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_valid <= 1'b0;
            buf_data  <= 32'd0;
        end else if (wb_flush || ms_allowin) begin
            buf_valid <= 1'b0;
        end else if (resp_hit) begin
            buf_valid <= 1'b1;
            buf_data  <= data_sram_rdata;
        end
    end
`endif

`ifndef SYNTHESIS
    discard_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(disc_inc && !disc_dec && discard_cnt == CntMax));
`ifndef MS_RDATA_BUF_EN
    // Without the buffer the response must be consumed by WB in the cycle it arrives
    resp_needs_wb: assert property (@(posedge clk) disable iff (!resetn)
        !(resp_hit && !ws_allowin && !wb_flush));
`endif
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: load extension, flush discard, forwarding,
// reset and (with MS_RDATA_BUF_EN) back-pressure buffering.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [31:0] es_result;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic [2:0]  es_ld_op;
    logic        es_mem_req;
    logic        es_ex;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [31:0] ms_final_result;
    logic [4:0]  ms_dest;
    logic        ms_gr_we;
    logic        ms_ex;
    logic        wb_flush;
    logic [4:0]  ms_fwd_dest;
    logic        ms_fwd_blocking;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_stage #(.DISCARD_W(2)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_to_ms_valid    (es_to_ms_valid),
        .ms_allowin        (ms_allowin),
        .es_pc             (es_pc),
        .es_result         (es_result),
        .es_dest           (es_dest),
        .es_gr_we          (es_gr_we),
        .es_ld_op          (es_ld_op),
        .es_mem_req        (es_mem_req),
        .es_ex             (es_ex),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_pc             (ms_pc),
        .ms_final_result   (ms_final_result),
        .ms_dest           (ms_dest),
        .ms_gr_we          (ms_gr_we),
        .ms_ex             (ms_ex),
        .wb_flush          (wb_flush),
        .ms_fwd_dest       (ms_fwd_dest),
        .ms_fwd_blocking   (ms_fwd_blocking)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single cycle; returns just after the capturing edge.
    task automatic issue(input logic [31:0] pc, input logic [31:0] addr, input logic [4:0] dest,
                         input logic we, input logic [2:0] op, input logic req, input logic ex);
        es_pc          = pc;
        es_result      = addr;
        es_dest        = dest;
        es_gr_we       = we;
        es_ld_op       = op;
        es_mem_req     = req;
        es_ex          = ex;
        es_to_ms_valid = 1'b1;
        step();
        es_to_ms_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", ms_to_ws_valid); end
        n_cmp++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL rst_allowin: got %b want 1", ms_allowin); end
        n_cmp++; if (ms_fwd_dest !== 5'd0) begin n_fail++; $display("FAIL rst_fwd_dest: got %0d want 0", ms_fwd_dest); end
        n_cmp++; if (ms_fwd_blocking !== 1'b0) begin n_fail++; $display("FAIL rst_blocking: got %b want 0", ms_fwd_blocking); end
        n_cmp++; if (ms_pc !== 32'd0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", ms_pc); end
    endtask

    task automatic test_load_byte();
        issue(32'h0000_0100, 32'h0000_1003, 5'd4, 1'b1, 3'd2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (ms_fwd_blocking !== 1'b1) begin n_fail++; $display("FAIL ldb_blocking[%0d]: got %b want 1", i, ms_fwd_blocking); end
            n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL ldb_wait_valid[%0d]: got %b want 0", i, ms_to_ws_valid); end
            n_cmp++; if (ms_allowin !== 1'b0) begin n_fail++; $display("FAIL ldb_allowin[%0d]: got %b want 0", i, ms_allowin); end
            step();
        end
        n_cmp++; if (ms_fwd_dest !== 5'd4) begin n_fail++; $display("FAIL ldb_fwd_dest: got %0d want 4", ms_fwd_dest); end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_1234;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL ldb_valid: got %b want 1", ms_to_ws_valid); end
        n_cmp++; if (ms_final_result !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL ldb_result: got %h want ffffff80", ms_final_result); end
        n_cmp++; if (ms_fwd_blocking !== 1'b0) begin n_fail++; $display("FAIL ldb_blocking_hit: got %b want 0", ms_fwd_blocking); end
        n_cmp++; if (ms_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL ldb_pc: got %h want 00000100", ms_pc); end
        step();
        data_sram_data_ok = 1'b0;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL ldb_after: got %b want 0", ms_to_ws_valid); end
    endtask

    task automatic test_load_half();
        issue(32'h0000_0200, 32'h0000_2002, 5'd6, 1'b1, 3'd5, 1'b1, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBEEF_0001;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL ldhu_valid: got %b want 1", ms_to_ws_valid); end
        n_cmp++; if (ms_final_result !== 32'h0000_BEEF) begin n_fail++; $display("FAIL ldhu_result: got %h want 0000beef", ms_final_result); end
        step();
        data_sram_data_ok = 1'b0;
        issue(32'h0000_0204, 32'h0000_2002, 5'd6, 1'b1, 3'd4, 1'b1, 1'b0);
        data_sram_data_ok = 1'b1;
        #1;
        n_cmp++; if (ms_final_result !== 32'hFFFF_BEEF) begin n_fail++; $display("FAIL ldh_result: got %h want ffffbeef", ms_final_result); end
        step();
        data_sram_data_ok = 1'b0;
        issue(32'h0000_0208, 32'h0000_2000, 5'd6, 1'b1, 3'd4, 1'b1, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1234_8001;
        #1;
        n_cmp++; if (ms_final_result !== 32'hFFFF_8001) begin n_fail++; $display("FAIL ldh_lo_result: got %h want ffff8001", ms_final_result); end
        step();
        data_sram_data_ok = 1'b0;
        issue(32'h0000_020C, 32'h0000_1002, 5'd6, 1'b1, 3'd3, 1'b1, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_1234;
        #1;
        n_cmp++; if (ms_final_result !== 32'h0000_00FF) begin n_fail++; $display("FAIL ldbu_result: got %h want 000000ff", ms_final_result); end
        step();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_flush_discard();
        issue(32'h0000_0300, 32'h0000_3000, 5'd5, 1'b1, 3'd1, 1'b1, 1'b0);
        wb_flush = 1'b1;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid: got %b want 0", ms_to_ws_valid); end
        step();
        wb_flush = 1'b0;
        #1;
        n_cmp++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL fl_allowin: got %b want 1", ms_allowin); end
        n_cmp++; if (ms_fwd_dest !== 5'd0) begin n_fail++; $display("FAIL fl_fwd_dest: got %0d want 0", ms_fwd_dest); end
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL fl_drop_valid: got %b want 0", ms_to_ws_valid); end
        step();
        data_sram_data_ok = 1'b0;
        issue(32'h0000_0304, 32'h0000_3004, 5'd5, 1'b1, 3'd1, 1'b1, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_1111;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL fl_next_valid: got %b want 1", ms_to_ws_valid); end
        n_cmp++; if (ms_final_result !== 32'h1111_1111) begin n_fail++; $display("FAIL fl_next_result: got %h want 11111111", ms_final_result); end
        step();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_flush_overlap();
        // Stale response lands while a fresh load waits: it must be dropped, not delivered.
        issue(32'h0000_0400, 32'h0000_4000, 5'd8, 1'b1, 3'd1, 1'b1, 1'b0);
        wb_flush = 1'b1;
        step();
        wb_flush = 1'b0;
        issue(32'h0000_0404, 32'h0000_4004, 5'd8, 1'b1, 3'd1, 1'b1, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hAAAA_AAAA;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL ov_stale_valid: got %b want 0", ms_to_ws_valid); end
        n_cmp++; if (ms_fwd_blocking !== 1'b1) begin n_fail++; $display("FAIL ov_stale_blocking: got %b want 1", ms_fwd_blocking); end
        step();
        data_sram_rdata = 32'h2222_3333;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL ov_own_valid: got %b want 1", ms_to_ws_valid); end
        n_cmp++; if (ms_final_result !== 32'h2222_3333) begin n_fail++; $display("FAIL ov_own_result: got %h want 22223333", ms_final_result); end
        step();
        data_sram_data_ok = 1'b0;
        // Flush coinciding with a dropped response leaves the counter at 1.
        issue(32'h0000_0408, 32'h0000_4008, 5'd8, 1'b1, 3'd1, 1'b1, 1'b0);
        wb_flush = 1'b1;
        step();
        wb_flush = 1'b0;
        issue(32'h0000_040C, 32'h0000_400C, 5'd8, 1'b1, 3'd1, 1'b1, 1'b0);
        wb_flush          = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBBBB_BBBB;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL ov_sim_valid: got %b want 0", ms_to_ws_valid); end
        step();
        wb_flush          = 1'b0;
        data_sram_data_ok = 1'b0;
        issue(32'h0000_0410, 32'h0000_4010, 5'd8, 1'b1, 3'd1, 1'b1, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCCCC_CCCC;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL ov_sim_drop: got %b want 0", ms_to_ws_valid); end
        step();
        data_sram_rdata = 32'h4444_5555;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL ov_sim_own_valid: got %b want 1", ms_to_ws_valid); end
        n_cmp++; if (ms_final_result !== 32'h4444_5555) begin n_fail++; $display("FAIL ov_sim_own_result: got %h want 44445555", ms_final_result); end
        step();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_non_mem();
        issue(32'h0000_0500, 32'h0000_0005, 5'd7, 1'b1, 3'd0, 1'b0, 1'b0);
        n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL alu_valid: got %b want 1", ms_to_ws_valid); end
        n_cmp++; if (ms_final_result !== 32'h0000_0005) begin n_fail++; $display("FAIL alu_result: got %h want 00000005", ms_final_result); end
        n_cmp++; if (ms_fwd_dest !== 5'd7) begin n_fail++; $display("FAIL alu_fwd_dest: got %0d want 7", ms_fwd_dest); end
        n_cmp++; if (ms_fwd_blocking !== 1'b0) begin n_fail++; $display("FAIL alu_blocking: got %b want 0", ms_fwd_blocking); end
        n_cmp++; if (ms_gr_we !== 1'b1 || ms_dest !== 5'd7) begin n_fail++; $display("FAIL alu_we_dest: got %b/%0d want 1/7", ms_gr_we, ms_dest); end
        ws_allowin = 1'b0;
        #1;
        n_cmp++; if (ms_allowin !== 1'b0) begin n_fail++; $display("FAIL alu_bp_allowin: got %b want 0", ms_allowin); end
        step();
        n_cmp++; if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'h5) begin n_fail++; $display("FAIL alu_hold: got %b/%h want 1/00000005", ms_to_ws_valid, ms_final_result); end
        ws_allowin = 1'b1;
        step();
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL alu_after: got %b want 0", ms_to_ws_valid); end
        n_cmp++; if (ms_fwd_dest !== 5'd0) begin n_fail++; $display("FAIL alu_after_fwd: got %0d want 0", ms_fwd_dest); end
    endtask

    task automatic test_exception_and_flush_capture();
        issue(32'h0000_0600, 32'h0000_6000, 5'd3, 1'b1, 3'd1, 1'b1, 1'b1);
        n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL ex_valid: got %b want 1", ms_to_ws_valid); end
        n_cmp++; if (ms_ex !== 1'b1) begin n_fail++; $display("FAIL ex_flag: got %b want 1", ms_ex); end
        n_cmp++; if (ms_fwd_blocking !== 1'b0) begin n_fail++; $display("FAIL ex_blocking: got %b want 0", ms_fwd_blocking); end
        step();
        es_gr_we       = 1'b1;
        es_dest        = 5'd9;
        es_ld_op       = 3'd0;
        es_mem_req     = 1'b0;
        es_ex          = 1'b0;
        es_to_ms_valid = 1'b1;
        wb_flush       = 1'b1;
        step();
        es_to_ms_valid = 1'b0;
        wb_flush       = 1'b0;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL flcap_valid: got %b want 0", ms_to_ws_valid); end
        n_cmp++; if (ms_fwd_dest !== 5'd0) begin n_fail++; $display("FAIL flcap_fwd: got %0d want 0", ms_fwd_dest); end
    endtask

`ifdef MS_RDATA_BUF_EN
    task automatic test_rdata_buffer();
        issue(32'h0000_0700, 32'h0000_7000, 5'd2, 1'b1, 3'd1, 1'b1, 1'b0);
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        #1;
        n_cmp++; if (ms_allowin !== 1'b0) begin n_fail++; $display("FAIL buf_allowin0: got %b want 0", ms_allowin); end
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0000_0000;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL buf_valid: got %b want 1", ms_to_ws_valid); end
        n_cmp++; if (ms_final_result !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL buf_result: got %h want cafef00d", ms_final_result); end
        n_cmp++; if (ms_allowin !== 1'b0) begin n_fail++; $display("FAIL buf_allowin1: got %b want 0", ms_allowin); end
        step();
        ws_allowin = 1'b1;
        #1;
        n_cmp++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL buf_release: got %b want 1", ms_allowin); end
        n_cmp++; if (ms_final_result !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL buf_result2: got %h want cafef00d", ms_final_result); end
        step();
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL buf_after: got %b want 0", ms_to_ws_valid); end
    endtask
`endif

    task automatic test_reset_mid_wait();
        issue(32'h0000_0800, 32'h0000_8000, 5'd9, 1'b1, 3'd1, 1'b1, 1'b0);
        wb_flush = 1'b1;
        step();
        wb_flush = 1'b0;
        issue(32'h0000_0804, 32'h0000_8004, 5'd9, 1'b1, 3'd1, 1'b1, 1'b0);
        n_cmp++; if (ms_fwd_blocking !== 1'b1) begin n_fail++; $display("FAIL rmw_pre_blocking: got %b want 1", ms_fwd_blocking); end
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL rmw_valid: got %b want 0", ms_to_ws_valid); end
        n_cmp++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL rmw_allowin: got %b want 1", ms_allowin); end
        n_cmp++; if (ms_fwd_dest !== 5'd0) begin n_fail++; $display("FAIL rmw_fwd: got %0d want 0", ms_fwd_dest); end
        n_cmp++; if (ms_fwd_blocking !== 1'b0) begin n_fail++; $display("FAIL rmw_blocking: got %b want 0", ms_fwd_blocking); end
        step();
        resetn = 1'b1;
        step();
        issue(32'h0000_0808, 32'h0000_8008, 5'd9, 1'b1, 3'd1, 1'b1, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h7777_8888;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL rmw_after_valid: got %b want 1", ms_to_ws_valid); end
        n_cmp++; if (ms_final_result !== 32'h7777_8888) begin n_fail++; $display("FAIL rmw_after_result: got %h want 77778888", ms_final_result); end
        step();
        data_sram_data_ok = 1'b0;
    endtask

    initial begin
        resetn            = 1'b0;
        es_to_ms_valid    = 1'b0;
        es_pc             = 32'd0;
        es_result         = 32'd0;
        es_dest           = 5'd0;
        es_gr_we          = 1'b0;
        es_ld_op          = 3'd0;
        es_mem_req        = 1'b0;
        es_ex             = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        ws_allowin        = 1'b1;
        wb_flush          = 1'b0;
        #3;
        test_reset();
        step();
        step();
        resetn = 1'b1;
        step();
        test_load_byte();
        test_load_half();
        test_flush_discard();
        test_flush_overlap();
        test_non_mem();
        test_exception_and_flush_capture();
`ifdef MS_RDATA_BUF_EN
        test_rdata_buffer();
`endif
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
